// File: rtl/CDB_types.sv
// Shared types and sizes for the rename datapath.
//   P_REG_NUM / FL_DEPTH : physical register file and free-list depth
//   ARCH_REG_NUM         : architectural register count (x0 never renamed)
//   PW / HW              : physical register index and free-list head widths
//   rat_entry_t          : one RAT entry {physical register, value ready}
//   rename_out_t         : renamed instruction bundle (without payload)
package CDB_types;

    localparam int P_REG_NUM    = 64;
    localparam int FL_DEPTH     = 32;
    localparam int ARCH_REG_NUM = 32;
    localparam int PW           = $clog2(P_REG_NUM);
    localparam int HW           = $clog2(FL_DEPTH) + 1;

    typedef logic [PW-1:0] preg_t;

    typedef struct packed {
        preg_t preg;
        logic  rdy;
    } rat_entry_t;

    typedef struct packed {
        logic          valid;
        preg_t         pd;
        preg_t         pd_old;
        preg_t         ps1;
        preg_t         ps2;
        logic          ps1_rdy;
        logic          ps2_rdy;
        logic [4:0]    rd;
        logic          we;
        logic [HW-1:0] fl_head;
    } rename_out_t;

    // An instruction needs a new physical register only if it writes a real rd.
    function automatic logic needs_alloc(input logic rd_we, input logic [4:0] rd);
        return rd_we && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/rename_stage_rat.sv
// Register alias table: architectural -> physical mapping plus ready bits.
//   ra1/ra2/ra3 -> rp*/rr* : three combinational read ports (rs1, rs2, rd)
//   we/wa/wd               : rename write (clears the ready bit)
//   cdb_valid/cdb_pd       : completion wakeup, also bypassed into the reads
//   flush/rrat_map         : restore from the retirement image, all ready
module rat
    import CDB_types::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [ARCH_REG_NUM*PW-1:0] rrat_map,
    input  logic [4:0]                 ra1,
    input  logic [4:0]                 ra2,
    input  logic [4:0]                 ra3,
    output logic [PW-1:0]              rp1,
    output logic [PW-1:0]              rp2,
    output logic [PW-1:0]              rp3,
    output logic                       rr1,
    output logic                       rr2,
    input  logic                       we,
    input  logic [4:0]                 wa,
    input  logic [PW-1:0]              wd,
    input  logic                       cdb_valid,
    input  logic [PW-1:0]              cdb_pd
);

    rat_entry_t rat_r [ARCH_REG_NUM];
    rat_entry_t rd1_s;
    rat_entry_t rd2_s;
    rat_entry_t rd3_s;

    // x0 reads as phys 0 and always ready; a same-cycle CDB match reads as ready.
    function automatic rat_entry_t lookup(input logic [4:0] a, input rat_entry_t e,
                                          input logic cv, input preg_t cp);
        rat_entry_t r;
        if (a == 5'd0) begin
            r.preg = '0;
            r.rdy  = 1'b1;
        end else begin
            r.preg = e.preg;
            r.rdy  = e.rdy || (cv && (e.preg == cp));
        end
        return r;
    endfunction

    assign rd1_s = lookup(ra1, rat_r[ra1], cdb_valid, cdb_pd);
    assign rd2_s = lookup(ra2, rat_r[ra2], cdb_valid, cdb_pd);
    assign rd3_s = lookup(ra3, rat_r[ra3], cdb_valid, cdb_pd);
    assign rp1   = rd1_s.preg;
    assign rp2   = rd2_s.preg;
    assign rp3   = rd3_s.preg;
    assign rr1   = rd1_s.rdy;
    assign rr2   = rd2_s.rdy;

    // Table update: reset identity map, flush restore, else rename beats CDB wakeup.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ARCH_REG_NUM; i++) begin
            if (rst) begin
                rat_r[i].preg <= PW'(i);
                rat_r[i].rdy  <= 1'b1;
            end else if (flush) begin
                rat_r[i].preg <= rrat_map[i*PW +: PW];
                rat_r[i].rdy  <= 1'b1;
            end else if (we && (wa == 5'(i)) && (i != 0)) begin
                rat_r[i].preg <= wd;
                rat_r[i].rdy  <= 1'b0;
            end else if (cdb_valid && (rat_r[i].preg == cdb_pd)) begin
                rat_r[i].rdy  <= 1'b1;
            end else begin
                rat_r[i] <= rat_r[i];
            end
        end
    end

endmodule

// File: rtl/rename_stage.sv
// Rename stage: accepts decoded instructions (S0), renames them in S1 using
// the RAT and the free-list output, and hands them to dispatch.
//   dec_*  : decode handshake and instruction fields
//   fl_*   : free-list dequeue request, allocated register, empty, head
//   cdb_*  : completion broadcast (ready wakeup)
//   flush / rrat_map : recovery to the retirement mapping
//   ren_*  : renamed instruction to dispatch/ROB
module rename_stage
    import CDB_types::*;
#(
    parameter int PAYLOAD_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       dec_valid,
    output logic                       dec_ready,
    input  logic [4:0]                 dec_rd,
    input  logic [4:0]                 dec_rs1,
    input  logic [4:0]                 dec_rs2,
    input  logic                       dec_rd_we,
    input  logic [PAYLOAD_W-1:0]       dec_payload,
    output logic                       fl_deq,
    input  logic [PW-1:0]              fl_pd,
    input  logic                       fl_empty,
    input  logic [HW-1:0]              fl_head,
    input  logic                       cdb_valid,
    input  logic [PW-1:0]              cdb_pd,
    input  logic                       flush,
    input  logic [ARCH_REG_NUM*PW-1:0] rrat_map,
    output logic                       ren_valid,
    input  logic                       ren_ready,
    output logic [PW-1:0]              ren_pd,
    output logic [PW-1:0]              ren_pd_old,
    output logic [PW-1:0]              ren_ps1,
    output logic [PW-1:0]              ren_ps2,
    output logic                       ren_ps1_rdy,
    output logic                       ren_ps2_rdy,
    output logic [4:0]                 ren_rd,
    output logic                       ren_we,
    output logic [HW-1:0]              ren_fl_head,
    output logic [PAYLOAD_W-1:0]       ren_payload
);

    logic                 s1_valid_r;
    logic [4:0]           s1_rd_r;
    logic [4:0]           s1_rs1_r;
    logic [4:0]           s1_rs2_r;
    logic                 s1_alloc_r;
    logic [PAYLOAD_W-1:0] s1_payload_r;

    logic                 alloc_in_s;
    logic                 fire_s;
    logic                 take_s;
    logic [PW-1:0]        ps1_s;
    logic [PW-1:0]        ps2_s;
    logic [PW-1:0]        pd_old_s;
    logic                 ps1_rdy_s;
    logic                 ps2_rdy_s;
    rename_out_t          out_s;

    // S0 handshake: S1 must be free or draining, and an allocation needs a free register.
    always_comb begin
        alloc_in_s = needs_alloc(dec_rd_we, dec_rd);
        fire_s     = s1_valid_r && ren_ready;
        dec_ready  = !flush && (!s1_valid_r || fire_s) && (!alloc_in_s || !fl_empty);
        take_s     = dec_valid && dec_ready;
        fl_deq     = take_s && alloc_in_s && !rst;
    end

    // S1 register: flush kills, accept loads, fire empties, otherwise hold (stall).
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r   <= 1'b0;
            s1_rd_r      <= 5'd0;
            s1_rs1_r     <= 5'd0;
            s1_rs2_r     <= 5'd0;
            s1_alloc_r   <= 1'b0;
            s1_payload_r <= '0;
        end else if (flush) begin
            s1_valid_r   <= 1'b0;
        end else if (take_s) begin
            s1_valid_r   <= 1'b1;
            s1_rd_r      <= dec_rd;
            s1_rs1_r     <= dec_rs1;
            s1_rs2_r     <= dec_rs2;
            s1_alloc_r   <= alloc_in_s;
            s1_payload_r <= dec_payload;
        end else if (fire_s) begin
            s1_valid_r   <= 1'b0;
        end else begin
            s1_valid_r   <= s1_valid_r;
        end
    end

    rat u_rat (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .rrat_map  (rrat_map),
        .ra1       (s1_rs1_r),
        .ra2       (s1_rs2_r),
        .ra3       (s1_rd_r),
        .rp1       (ps1_s),
        .rp2       (ps2_s),
        .rp3       (pd_old_s),
        .rr1       (ps1_rdy_s),
        .rr2       (ps2_rdy_s),
        .we        (fire_s && s1_alloc_r),
        .wa        (s1_rd_r),
        .wd        (fl_pd),
        .cdb_valid (cdb_valid),
        .cdb_pd    (cdb_pd)
    );

    // Renamed bundle; everything reads as zero while S1 is empty.
    always_comb begin
        out_s = '0;
        if (s1_valid_r) begin
            out_s.valid   = 1'b1;
            out_s.pd      = s1_alloc_r ? fl_pd : '0;
            out_s.pd_old  = pd_old_s;
            out_s.ps1     = ps1_s;
            out_s.ps2     = ps2_s;
            out_s.ps1_rdy = ps1_rdy_s;
            out_s.ps2_rdy = ps2_rdy_s;
            out_s.rd      = s1_rd_r;
            out_s.we      = s1_alloc_r;
            out_s.fl_head = fl_head;
        end else begin
            out_s = '0;
        end
    end

    assign ren_valid   = out_s.valid;
    assign ren_pd      = out_s.pd;
    assign ren_pd_old  = out_s.pd_old;
    assign ren_ps1     = out_s.ps1;
    assign ren_ps2     = out_s.ps2;
    assign ren_ps1_rdy = out_s.ps1_rdy;
    assign ren_ps2_rdy = out_s.ps2_rdy;
    assign ren_rd      = out_s.rd;
    assign ren_we      = out_s.we;
    assign ren_fl_head = out_s.fl_head;
    assign ren_payload = s1_valid_r ? s1_payload_r : '0;

endmodule

// File: tb/tb_rename_stage.sv
// Directed bench for rename_stage: hand-computed vectors, one linear sequence.
module tb_rename_stage;
    import CDB_types::*;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       dec_valid;
    logic                       dec_ready;
    logic [4:0]                 dec_rd, dec_rs1, dec_rs2;
    logic                       dec_rd_we;
    logic [63:0]                dec_payload;
    logic                       fl_deq;
    logic [PW-1:0]              fl_pd;
    logic                       fl_empty;
    logic [HW-1:0]              fl_head;
    logic                       cdb_valid;
    logic [PW-1:0]              cdb_pd;
    logic                       flush;
    logic [ARCH_REG_NUM*PW-1:0] rrat_map;
    logic                       ren_valid, ren_ready;
    logic [PW-1:0]              ren_pd, ren_pd_old, ren_ps1, ren_ps2;
    logic                       ren_ps1_rdy, ren_ps2_rdy;
    logic [4:0]                 ren_rd;
    logic                       ren_we;
    logic [HW-1:0]              ren_fl_head;
    logic [63:0]                ren_payload;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rename_stage #(.PAYLOAD_W(64)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rd_we(dec_rd_we), .dec_payload(dec_payload),
        .fl_deq(fl_deq), .fl_pd(fl_pd), .fl_empty(fl_empty), .fl_head(fl_head),
        .cdb_valid(cdb_valid), .cdb_pd(cdb_pd),
        .flush(flush), .rrat_map(rrat_map),
        .ren_valid(ren_valid), .ren_ready(ren_ready),
        .ren_pd(ren_pd), .ren_pd_old(ren_pd_old),
        .ren_ps1(ren_ps1), .ren_ps2(ren_ps2),
        .ren_ps1_rdy(ren_ps1_rdy), .ren_ps2_rdy(ren_ps2_rdy),
        .ren_rd(ren_rd), .ren_we(ren_we),
        .ren_fl_head(ren_fl_head), .ren_payload(ren_payload)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic we);
        dec_valid = v;
        dec_rd    = rd;
        dec_rs1   = rs1;
        dec_rs2   = rs2;
        dec_rd_we = we;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; cdb_valid = 1'b0; cdb_pd = '0;
        fl_pd = '0; fl_empty = 1'b0; fl_head = '0; ren_ready = 1'b1;
        dec_payload = 64'h0;
        present(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < ARCH_REG_NUM; i++) rrat_map[i*PW +: PW] = PW'(i);
        rrat_map[5*PW +: PW] = PW'(7);
        fl_head = HW'(9);
        tick(); tick();
        rst = 1'b0;

        // Reset state
        chk("rst_ren_valid", ren_valid, 0);
        chk("rst_dec_ready", dec_ready, 1);
        chk("rst_fl_deq", fl_deq, 0);
        chk("rst_ren_pd", ren_pd, 0);
        chk("rst_ren_ps1", ren_ps1, 0);
        chk("rst_ren_fl_head", ren_fl_head, 0);

        // add x5 <- x1, x2 ; next instruction x6 <- x5 back to back
        present(1'b1, 5'd5, 5'd1, 5'd2, 1'b1);
        dec_payload = 64'hDEAD_BEEF_0123_4567;
        #1;
        chk("i1_fl_deq", fl_deq, 1);
        tick();
        present(1'b1, 5'd6, 5'd5, 5'd0, 1'b1);
        dec_payload = 64'h1111;
        fl_pd = PW'(32); fl_head = HW'(33);
        #1;
        chk("i1_ren_valid", ren_valid, 1);
        chk("i1_ps1", ren_ps1, 1);
        chk("i1_ps2", ren_ps2, 2);
        chk("i1_rdy", {ren_ps1_rdy, ren_ps2_rdy}, 2'b11);
        chk("i1_pd", ren_pd, 32);
        chk("i1_pd_old", ren_pd_old, 5);
        chk("i1_fl_head", ren_fl_head, 33);
        chk("i1_rd_we", {ren_rd, ren_we}, {5'd5, 1'b1});
        chk("i1_payload", ren_payload, 64'hDEAD_BEEF_0123_4567);
        chk("i2_dec_ready", dec_ready, 1);
        chk("i2_fl_deq", fl_deq, 1);
        tick();
        present(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        fl_pd = PW'(33); fl_head = HW'(34);
        #1;
        chk("i2_ren_valid", ren_valid, 1);
        chk("i2_ps1", ren_ps1, 32);
        chk("i2_ps1_rdy", ren_ps1_rdy, 0);
        chk("i2_ps2", {ren_ps2, ren_ps2_rdy}, {6'd0, 1'b1});
        chk("i2_pd", ren_pd, 33);
        chk("i2_pd_old", ren_pd_old, 6);
        tick();
        chk("i2_drained", ren_valid, 0);

        // Reader of x5 (phys 32) and x6 (phys 33) while CDB broadcasts 32
        present(1'b1, 5'd0, 5'd5, 5'd6, 1'b0);
        tick();
        present(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        ren_ready = 1'b0;
        cdb_valid = 1'b1; cdb_pd = PW'(32);
        #1;
        chk("byp_ps1", ren_ps1, 32);
        chk("byp_ps1_rdy", ren_ps1_rdy, 1);
        chk("byp_ps2_rdy", ren_ps2_rdy, 0);
        chk("byp_pd_nonalloc", {ren_pd, ren_we}, 7'd0);
        tick();
        cdb_valid = 1'b0;
        #1;
        chk("wake_ps1_rdy", ren_ps1_rdy, 1);
        chk("wake_ps2_rdy", ren_ps2_rdy, 0);
        ren_ready = 1'b1;
        tick();

        // Rename x5 -> 34 in the same cycle CDB broadcasts 32; reader follows
        present(1'b1, 5'd5, 5'd0, 5'd0, 1'b1);
        tick();
        present(1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
        fl_pd = PW'(34); fl_head = HW'(35);
        cdb_valid = 1'b1; cdb_pd = PW'(32);
        #1;
        chk("race_pd_old", ren_pd_old, 32);
        tick();
        present(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        cdb_valid = 1'b0;
        #1;
        chk("race_ps1", ren_ps1, 34);
        chk("race_ps1_rdy", ren_ps1_rdy, 0);
        tick();

        // Free list empty: alloc blocked, store passes
        fl_empty = 1'b1;
        present(1'b1, 5'd9, 5'd1, 5'd2, 1'b1);
        #1;
        chk("empty_dec_ready", dec_ready, 0);
        chk("empty_fl_deq", fl_deq, 0);
        tick();
        chk("empty_no_accept", ren_valid, 0);
        present(1'b1, 5'd9, 5'd3, 5'd4, 1'b0);
        #1;
        chk("store_dec_ready", dec_ready, 1);
        chk("store_fl_deq", fl_deq, 0);
        tick();
        present(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        fl_empty = 1'b0;
        #1;
        chk("store_ren_valid", ren_valid, 1);
        chk("store_pd_we", {ren_pd, ren_we}, 7'd0);
        chk("store_ps", {ren_ps1, ren_ps2}, {6'd3, 6'd4});
        tick();

        // Stall 3 cycles, then flush with rrat_map[5] = 7
        present(1'b1, 5'd10, 5'd3, 5'd4, 1'b1);
        ren_ready = 1'b0;
        tick();
        present(1'b1, 5'd11, 5'd1, 5'd1, 1'b1);
        fl_pd = PW'(35); fl_head = HW'(36);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_valid", ren_valid, 1);
            chk("stall_pd", ren_pd, 35);
            chk("stall_ps", {ren_ps1, ren_ps2}, {6'd3, 6'd4});
            chk("stall_pd_old", ren_pd_old, 10);
            chk("stall_fl_head", ren_fl_head, 36);
            chk("stall_dec_ready", dec_ready, 0);
            chk("stall_fl_deq", fl_deq, 0);
            tick();
        end
        flush = 1'b1;
        #1;
        chk("flush_fl_deq", fl_deq, 0);
        chk("flush_dec_ready", dec_ready, 0);
        tick();
        flush = 1'b0;
        present(1'b1, 5'd6, 5'd5, 5'd10, 1'b0);
        ren_ready = 1'b1;
        #1;
        chk("flush_killed", ren_valid, 0);
        tick();
        present(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        #1;
        chk("rrat_ps1", {ren_ps1, ren_ps1_rdy}, {6'd7, 1'b1});
        chk("rrat_ps2", {ren_ps2, ren_ps2_rdy}, {6'd10, 1'b1});
        chk("rrat_pd_old", ren_pd_old, 6);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
